hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage pipelined core (F/D/E/M/W).
- Generalises forwarding to NRP source operands and adds an optional hard-zero-register mode.
- Adds a multi-cycle execute unit interlock (FSM + down-counter) and a memory-wait handshake stall that freezes F through M.
- Adds a saturating stall-cycle performance counter. Sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
AW, 5, register address width
NRP, 2, number of source operands per instruction (1..4)
MUL_LAT, 4, cycles a multi-cycle op occupies E (1..16)
ZERO_REG, 0, 1 = register 0 is hard-wired zero: never forwarded, never causes load-use stall
CNTW, 16, width of stall performance counter

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes a register
MemToRegE  in  1  instruction in E is a load
MulStartE  in  1  instruction in E is a multi-cycle op
MemReqM  in  1  M stage has an outstanding data-memory access
MemReadyM  in  1  data memory completes access this cycle
BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  control-flow events per stage
RAD  in  NRP*AW  packed source addresses in D (operand i at [i*AW +: AW])
RAE  in  NRP*AW  packed source addresses in E
WA3E, WA3M, WA3W  in  AW each  destination addresses
StallF, StallD, StallE, StallM  out  1 each  hold stage register
FlushD, FlushE, FlushM, FlushW  out  1 each  bubble into stage register
ForwardE  out  2*NRP  per-operand select: 00 regfile, 01 W result, 10 M ALU result
MulBusy  out  1  multi-cycle FSM in BUSY
StallCnt  out  CNTW  saturating count of cycles with StallF=1

Behaviour:
- Reset low (any time, async): FSM→IDLE, mul counter=0, StallCnt=0; all outputs 0 while Reset low. Mid-operation reset aborts the multi-cycle op.
- Valid(a): ZERO_REG=0 → 1; ZERO_REG=1 → a!=0.
- Forwarding (combinational), per operand i: 10 if RAE[i]==WA3M & RegWriteM & Valid; else 01 if RAE[i]==WA3W & RegWriteW & Valid; else 00. M has priority over W.
- LdStall = MemToRegE & RegWriteE & (any i: RAD[i]==WA3E & Valid(RAD[i])).
- MemWait = MemReqM & ~MemReadyM.
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- Multi-cycle FSM, IDLE/BUSY, counter width clog2(MUL_LAT+1):
  - IDLE & MulStartE & ~MemWait & MUL_LAT>1 → cnt<=MUL_LAT-1, go BUSY; MulStall=1 this cycle.
  - BUSY: MulStall = cnt>1. If ~MemWait: cnt<=cnt-1; at cnt==1 go IDLE.
  - MulStartE is ignored in BUSY.
  - MUL_LAT=1: FSM never leaves IDLE.
  - Total stalled cycles = MUL_LAT-1 (excluding MemWait cycles).
  - MemWait freezes the counter.
- Priority of outputs, highest first:
  1. MemWait: StallF=StallD=StallE=StallM=1, FlushW=1; all other flushes 0.
  2. MulStall: StallF=StallD=StallE=1, FlushM=1; FlushD=FlushE=0. LdStall and branch are ignored because the E instruction is frozen.
  3. BranchTakenE: FlushD=1, FlushE=1, StallD=0. LdStall is suppressed because D holds a wrong-path instruction. StallF=PCWrPending.
  4. Otherwise:
     - StallD = LdStall
     - StallF = LdStall | PCWrPending
     - FlushE = LdStall
     - FlushD = PCWrPending | PCSrcW
- StallE, StallM, FlushM, FlushW are 0 unless stated above.
- MulBusy = (state==BUSY).
- StallCnt increments on each clock with StallF=1 and saturates at 2^CNTW-1.

Test Plan:
- Forward priority: NRP=2, RAE={3,3}, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardE={10,10}. Drop RegWriteM → {01,01}.
- Zero register: ZERO_REG=1, RAE[0]=0, WA3M=0, RegWriteM=1 → ForwardE[1:0]=00. Same with MemToRegE=1, RAD[0]=0, WA3E=0 → no StallD.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RAD[1]=5 → StallF=StallD=FlushE=1 for one cycle. Add BranchTakenE=1 → StallD=0, FlushD=FlushE=1.
- Multi-cycle: MUL_LAT=4, MulStartE held 4 cycles → StallE=1 for exactly 3 cycles, MulBusy=1 cycles 2-4, FlushM=1 during the 3 stall cycles. Insert MemWait in cycle 2 → total stall becomes 4 cycles, with StallM=1 and FlushW=1 in the wait cycle.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → StallF..StallM=1 and FlushW=1 for 3 cycles, 0 on the ready cycle. StallCnt increases by 3.
- Reset mid-op: deassert Reset in BUSY cycle 2 → all outputs 0 immediately (async), MulBusy=0, StallCnt=0. After release with MulStartE=0 → IDLE, no stall.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard unit: forwarding, load-use, multi-cycle and memory-wait interlocks
// Drives stall/flush/forward selects for the F/D/E/M/W core and counts stalled fetch cycles.
module hazard_unit_mc #(
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int MUL_LAT  = 4,
    parameter int ZERO_REG = 0,
    parameter int CNTW     = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                RegWriteE,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    input  logic                MemToRegE,
    input  logic                MulStartE,
    input  logic                MemReqM,
    input  logic                MemReadyM,
    input  logic                BranchTakenE,
    input  logic                PCSrcD,
    input  logic                PCSrcE,
    input  logic                PCSrcM,
    input  logic                PCSrcW,
    input  logic [NRP*AW-1:0]   RAD,
    input  logic [NRP*AW-1:0]   RAE,
    input  logic [AW-1:0]       WA3E,
    input  logic [AW-1:0]       WA3M,
    input  logic [AW-1:0]       WA3W,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                StallM,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushM,
    output logic                FlushW,
    output logic [2*NRP-1:0]    ForwardE,
    output logic                MulBusy,
    output logic [CNTW-1:0]     StallCnt
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic [2*NRP-1:0] fwd;
    logic             ld_stall;
    logic             mem_wait;
    logic             pc_wr_pending;
    logic             mul_stall;
    logic             s_f, s_d, s_e, s_m;
    logic             f_d, f_e, f_m, f_w;

    function automatic logic valid_addr(input logic [AW-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    assign mem_wait      = MemReqM & ~MemReadyM;
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    always_comb begin
        fwd = '0;
        for (int i = 0; i < NRP; i++) begin
            if (RegWriteM && (RAE[i*AW +: AW] == WA3M) && valid_addr(RAE[i*AW +: AW])) begin
                fwd[2*i +: 2] = 2'b10;
            end else if (RegWriteW && (RAE[i*AW +: AW] == WA3W) && valid_addr(RAE[i*AW +: AW])) begin
                fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        ld_stall = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            if ((RAD[i*AW +: AW] == WA3E) && valid_addr(RAD[i*AW +: AW])) begin
                ld_stall = 1'b1;
            end
        end
        ld_stall = ld_stall & MemToRegE & RegWriteE;
    end

    // The counter holds the remaining E-occupancy cycles; the last one is not a stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulStartE && !mem_wait && (MUL_LAT > 1)) begin
                    state_d   = BUSY;
                    cnt_d     = CW'(MUL_LAT - 1);
                    mul_stall = 1'b1;
                end
            end
            BUSY: begin
                mul_stall = (cnt_q > CW'(1));
                if (!mem_wait) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_f = 1'b0;
        s_d = 1'b0;
        s_e = 1'b0;
        s_m = 1'b0;
        f_d = 1'b0;
        f_e = 1'b0;
        f_m = 1'b0;
        f_w = 1'b0;
        if (mem_wait) begin
            s_f = 1'b1;
            s_d = 1'b1;
            s_e = 1'b1;
            s_m = 1'b1;
            f_w = 1'b1;
        end else if (mul_stall) begin
            // E is frozen, so load-use and branch resolution wait for the op to drain.
            s_f = 1'b1;
            s_d = 1'b1;
            s_e = 1'b1;
            f_m = 1'b1;
        end else if (BranchTakenE) begin
            f_d = 1'b1;
            f_e = 1'b1;
            s_f = pc_wr_pending;
        end else begin
            s_d = ld_stall;
            s_f = ld_stall | pc_wr_pending;
            f_e = ld_stall;
            f_d = pc_wr_pending | PCSrcW;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s_f && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational selects are forced low while reset is held.
    assign StallF   = Reset & s_f;
    assign StallD   = Reset & s_d;
    assign StallE   = Reset & s_e;
    assign StallM   = Reset & s_m;
    assign FlushD   = Reset & f_d;
    assign FlushE   = Reset & f_e;
    assign FlushM   = Reset & f_m;
    assign FlushW   = Reset & f_w;
    assign ForwardE = Reset ? fwd : '0;
    assign MulBusy  = (state_q == BUSY);
    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed and randomized bench for hazard_unit_mc against a behavioural model
module tb_hazard_unit_mc;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MulStartE, MemReqM, MemReadyM;
    logic       BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic [9:0] RAD, RAE;
    logic [4:0] WA3E, WA3M, WA3W;

    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MulBusy;
    logic [3:0]  ForwardE;
    logic [15:0] StallCnt;
    logic        StallF_z, StallD_z, StallE_z, StallM_z, FlushD_z, FlushE_z, FlushM_z, FlushW_z, MulBusy_z;
    logic [3:0]  ForwardE_z;
    logic [1:0]  StallCnt_z;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic sf, sd, se, sm, fd, fe, fm, fw;
        logic [3:0] fwd;
        logic mb;
    } exp_t;

    int left = 0, left_z = 0, nleft = 0, nleft_z = 0;
    int mcnt = 0, mcnt_z = 0, ncnt = 0, ncnt_z = 0;
    int snap;

    always #5 CLK = ~CLK;

    hazard_unit_mc #(.AW(5), .NRP(2), .MUL_LAT(4), .ZERO_REG(0), .CNTW(16)) dut (
        .CLK(CLK), .Reset(Reset), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MulStartE(MulStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .RAD(RAD), .RAE(RAE), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardE(ForwardE), .MulBusy(MulBusy), .StallCnt(StallCnt)
    );

    hazard_unit_mc #(.AW(5), .NRP(2), .MUL_LAT(1), .ZERO_REG(1), .CNTW(2)) dut_z (
        .CLK(CLK), .Reset(Reset), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MulStartE(MulStartE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .RAD(RAD), .RAE(RAE), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .StallF(StallF_z), .StallD(StallD_z), .StallE(StallE_z), .StallM(StallM_z),
        .FlushD(FlushD_z), .FlushE(FlushE_z), .FlushM(FlushM_z), .FlushW(FlushW_z),
        .ForwardE(ForwardE_z), .MulBusy(MulBusy_z), .StallCnt(StallCnt_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int zr, input int ml, input int busy_left);
        exp_t e;
        logic [3:0] f;
        logic [4:0] ra;
        bit mw, ld, pcp, ms;
        e = '0;
        f = '0;
        if (!Reset) return e;
        for (int i = 0; i < 2; i++) begin
            ra = RAE[i*5 +: 5];
            if (!(zr == 1 && ra == 0)) begin
                if (RegWriteM && ra == WA3M)      f[2*i +: 2] = 2'b10;
                else if (RegWriteW && ra == WA3W) f[2*i +: 2] = 2'b01;
            end
        end
        e.fwd = f;
        ld = 0;
        for (int i = 0; i < 2; i++) begin
            ra = RAD[i*5 +: 5];
            if (MemToRegE && RegWriteE && ra == WA3E && !(zr == 1 && ra == 0)) ld = 1;
        end
        mw  = MemReqM && !MemReadyM;
        pcp = PCSrcD || PCSrcE || PCSrcM;
        ms  = (busy_left == 0) ? (MulStartE && !mw && ml > 1) : (busy_left > 1);
        e.mb = (busy_left > 0);
        if (mw) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else if (ms) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
        end else if (BranchTakenE) begin
            e.fd = 1; e.fe = 1; e.sf = pcp;
        end else begin
            e.sd = ld; e.sf = ld || pcp; e.fe = ld; e.fd = pcp || PCSrcW;
        end
        return e;
    endfunction

    function automatic int next_left(input int ml, input int busy_left);
        if (MemReqM && !MemReadyM) return busy_left;
        if (busy_left == 0) return (MulStartE && ml > 1) ? ml - 1 : 0;
        return busy_left - 1;
    endfunction

    task automatic check_now();
        exp_t e, ez;
        #1;
        if (!Reset) begin
            left = 0; left_z = 0; mcnt = 0; mcnt_z = 0;
        end
        e  = model(0, 4, left);
        ez = model(1, 1, left_z);
        chk("outs", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ForwardE, MulBusy}), 32'(e));
        chk("outs_z", 32'({StallF_z, StallD_z, StallE_z, StallM_z, FlushD_z, FlushE_z, FlushM_z, FlushW_z,
                          ForwardE_z, MulBusy_z}), 32'(ez));
        chk("stallcnt", 32'(StallCnt), 32'(mcnt));
        chk("stallcnt_z", 32'(StallCnt_z), 32'(mcnt_z));
        nleft   = next_left(4, left);
        nleft_z = next_left(1, left_z);
        ncnt    = (e.sf && mcnt < 65535) ? mcnt + 1 : mcnt;
        ncnt_z  = (ez.sf && mcnt_z < 3) ? mcnt_z + 1 : mcnt_z;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (Reset) begin
            left = nleft; left_z = nleft_z; mcnt = ncnt; mcnt_z = ncnt_z;
        end else begin
            left = 0; left_z = 0; mcnt = 0; mcnt_z = 0;
        end
    endtask

    task automatic idle_inputs();
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; MulStartE = 0;
        MemReqM = 0; MemReadyM = 0; BranchTakenE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
        RAD = '0; RAE = '0; WA3E = 5'd31; WA3M = 5'd31; WA3W = 5'd31;
    endtask

    initial begin
        Reset = 0;
        idle_inputs();
        RegWriteM = 1; WA3M = 0; MemReqM = 1;
        check_now();
        chk("reset_stallf", 32'(StallF), 32'(0));
        chk("reset_fwd", 32'(ForwardE), 32'(0));
        tick();
        Reset = 1;
        idle_inputs();

        RAE = {5'd3, 5'd3}; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
        check_now();
        chk("fwd_m_prio", 32'(ForwardE), 32'(4'b1010));
        tick();
        RegWriteM = 0;
        check_now();
        chk("fwd_w", 32'(ForwardE), 32'(4'b0101));
        tick();

        idle_inputs();
        RAE = {5'd7, 5'd0}; WA3M = 0; RegWriteM = 1;
        MemToRegE = 1; RegWriteE = 1; RAD = {5'd7, 5'd0}; WA3E = 0;
        check_now();
        chk("zero_fwd_z", 32'(ForwardE_z[1:0]), 32'(0));
        chk("zero_fwd", 32'(ForwardE), 32'(4'b0010));
        chk("zero_ld_z", 32'(StallD_z), 32'(0));
        chk("zero_ld", 32'(StallD), 32'(1));
        tick();

        idle_inputs();
        MemToRegE = 1; RegWriteE = 1; WA3E = 5; RAD = {5'd5, 5'd9};
        check_now();
        chk("ld_use", 32'({StallF, StallD, FlushE}), 32'(3'b111));
        tick();
        BranchTakenE = 1;
        check_now();
        chk("ld_branch", 32'({StallD, FlushD, FlushE}), 32'(3'b011));
        tick();

        idle_inputs();
        MulStartE = 1;
        for (int k = 0; k < 4; k++) begin
            check_now();
            chk("mul_stalle", 32'(StallE), 32'(k < 3));
            chk("mul_busy", 32'(MulBusy), 32'(k > 0));
            chk("mul_flushm", 32'(FlushM), 32'(k < 3));
            tick();
        end
        MulStartE = 0;
        check_now();
        tick();

        MulStartE = 1;
        for (int k = 0; k < 5; k++) begin
            MemReqM = (k == 1);
            check_now();
            chk("mulw_stalle", 32'(StallE), 32'(k < 4));
            chk("mulw_stallm", 32'({StallM, FlushW}), (k == 1) ? 32'(2'b11) : 32'(0));
            tick();
        end
        idle_inputs();

        snap = int'(StallCnt);
        MemReqM = 1;
        for (int k = 0; k < 4; k++) begin
            MemReadyM = (k == 3);
            check_now();
            chk("memw_stall", 32'({StallF, StallD, StallE, StallM, FlushW}), (k < 3) ? 32'(5'h1f) : 32'(0));
            tick();
        end
        chk("memw_cnt", 32'(StallCnt), 32'(snap + 3));
        idle_inputs();

        MulStartE = 1;
        check_now();
        tick();
        check_now();
        Reset = 0;
        check_now();
        chk("rst_mid_busy", 32'(MulBusy), 32'(0));
        chk("rst_mid_cnt", 32'(StallCnt), 32'(0));
        chk("rst_mid_stalle", 32'(StallE), 32'(0));
        tick();
        Reset = 1; MulStartE = 0;
        check_now();
        chk("rst_after", 32'({StallF, MulBusy}), 32'(0));
        tick();

        MemReqM = 1;
        for (int k = 0; k < 5; k++) begin
            check_now();
            tick();
        end
        chk("sat_cnt_z", 32'(StallCnt_z), 32'(3));
        idle_inputs();

        for (int n = 0; n < 400; n++) begin
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemToRegE = 1'($urandom); MulStartE = ($urandom_range(0, 7) == 0);
            MemReqM = ($urandom_range(0, 3) == 0); MemReadyM = 1'($urandom);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
            RAD = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            RAE = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            WA3E = 5'($urandom_range(0, 3)); WA3M = 5'($urandom_range(0, 3)); WA3W = 5'($urandom_range(0, 3));
            check_now();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
